butterfly_r2_cfg: RTL and testbench

- Parametrised radix-2 DIT butterfly, successor to the fixed 16-bit, 3-stage butterfly.
- Computes P = A + W'·B and Q = A − W'·B.
  - W' = W for forward FFT.
  - W' = conj(W) for inverse FFT, selected per transaction.
- Adds configurable data/twiddle widths, optional convergent-free rounding, per-transaction divide-by-2 stage scaling, output saturation with a sticky overflow flag, and valid/ready backpressure.
- Instantiated once per stage inside the FFT/IFFT datapath feeding the MVDR beamformer.

---
 rtl/butterfly_r2_cfg.sv | 169 ++++++++++++++++
 tb/tb_butterfly_r2_cfg.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_r2_cfg.sv
// Radix-2 DIT butterfly with a 3-stage valid/ready pipeline: P = A + W'B, Q = A - W'B.
// W' = conj(W) when inv is set. Optional rounding, divide-by-2 scaling, saturate or wrap, sticky ovf.

module butterfly_r2_cfg_sat #(
  parameter int DW    = 16,
  parameter int ROUND = 1,
  parameter int SAT   = 1
) (
  input  logic signed [DW+1:0] i_x,
  input  logic                 i_scale,
  output logic [DW-1:0]        o_y,
  output logic                 o_ovf
);
  // One extra bit so the +1 rounding term cannot wrap before the shift.
  localparam int XW = DW + 3;
  localparam logic signed [XW-1:0] RC   = (ROUND != 0) ? XW'(1) : XW'(0);
  localparam logic signed [XW-1:0] MAXV = (XW'(1) <<< (DW-1)) - XW'(1);
  localparam logic signed [XW-1:0] MINV = -(XW'(1) <<< (DW-1));

  logic signed [XW-1:0] w_x, w_s;
  logic                 w_hi, w_lo;

  assign w_x   = XW'(i_x);
  assign w_s   = i_scale ? ((w_x + RC) >>> 1) : w_x;
  assign w_hi  = w_s > MAXV;
  assign w_lo  = w_s < MINV;
  assign o_ovf = w_hi | w_lo;

  always_comb begin
    o_y = w_s[DW-1:0];
    if (SAT != 0 && w_hi)      o_y = MAXV[DW-1:0];
    else if (SAT != 0 && w_lo) o_y = MINV[DW-1:0];
  end
endmodule

module butterfly_r2_cfg #(
  parameter int DW    = 16,
  parameter int TW    = 16,
  parameter int ROUND = 1,
  parameter int SAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 inv,
  input  logic                 scale,
  input  logic signed [DW-1:0] ar,
  input  logic signed [DW-1:0] ai,
  input  logic signed [DW-1:0] br,
  input  logic signed [DW-1:0] bi,
  input  logic signed [TW-1:0] wr,
  input  logic signed [TW-1:0] wi,
  output logic signed [DW-1:0] pr,
  output logic signed [DW-1:0] pi,
  output logic signed [DW-1:0] qr,
  output logic signed [DW-1:0] qi,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 ovf,
  input  logic                 ovf_clr
);
  localparam int STAGES = 3;
  localparam int PW     = DW + TW + 1;
  localparam int SW     = DW + TW + 2;
  localparam int D2     = DW + 2;
  localparam logic signed [SW-1:0] RC = (ROUND != 0) ? (SW'(1) <<< (TW-2)) : SW'(0);

  typedef struct packed {
    logic signed [DW-1:0] a_re;
    logic signed [DW-1:0] a_im;
    logic                 scale;
    logic signed [PW-1:0] rr;
    logic signed [PW-1:0] ii;
    logic signed [PW-1:0] ri;
    logic signed [PW-1:0] ir;
  } s1_t;

  typedef struct packed {
    logic signed [D2-1:0] a_re;
    logic signed [D2-1:0] a_im;
    logic                 scale;
    logic signed [D2-1:0] wb_re;
    logic signed [D2-1:0] wb_im;
  } s2_t;

  logic [STAGES:1]         r_vld_pipe;
  s1_t                     r_s1, w_s1;
  s2_t                     r_s2, w_s2;
  logic [3:0][DW-1:0]      r_out;
  logic                    r_ovf;
  logic                    w_adv;
  logic signed [TW:0]      w_wi_ext, w_wi_eff;
  logic signed [SW-1:0]    w_re, w_im;
  logic [3:0][D2-1:0]      w_pq;
  logic [3:0][DW-1:0]      w_y;
  logic [3:0]              w_ovf;

  // The whole pipe freezes while the output is held; bubbles are not collapsed.
  assign w_adv    = !(r_vld_pipe[STAGES] && !out_ready);
  assign in_ready = w_adv;

  // Widen before negating so -2^(TW-1) conjugates to +2^(TW-1) exactly.
  assign w_wi_ext = {wi[TW-1], wi};

  always_comb begin
    w_wi_eff   = inv ? -w_wi_ext : w_wi_ext;
    w_s1       = '0;
    w_s1.a_re  = ar;
    w_s1.a_im  = ai;
    w_s1.scale = scale;
    w_s1.rr    = PW'(wr) * PW'(br);
    w_s1.ii    = PW'(w_wi_eff) * PW'(bi);
    w_s1.ri    = PW'(wr) * PW'(bi);
    w_s1.ir    = PW'(w_wi_eff) * PW'(br);
  end

  always_comb begin
    w_re       = SW'(r_s1.rr) - SW'(r_s1.ii);
    w_im       = SW'(r_s1.ri) + SW'(r_s1.ir);
    w_s2       = '0;
    w_s2.a_re  = D2'(r_s1.a_re);
    w_s2.a_im  = D2'(r_s1.a_im);
    w_s2.scale = r_s1.scale;
    w_s2.wb_re = D2'((w_re + RC) >>> (TW-1));
    w_s2.wb_im = D2'((w_im + RC) >>> (TW-1));
  end

  assign w_pq[0] = r_s2.a_re + r_s2.wb_re;
  assign w_pq[1] = r_s2.a_im + r_s2.wb_im;
  assign w_pq[2] = r_s2.a_re - r_s2.wb_re;
  assign w_pq[3] = r_s2.a_im - r_s2.wb_im;

  for (genvar g = 0; g < 4; g++) begin : g_sat
    butterfly_r2_cfg_sat #(.DW(DW), .ROUND(ROUND), .SAT(SAT)) u_sat (
      .i_x    (w_pq[g]),
      .i_scale(r_s2.scale),
      .o_y    (w_y[g]),
      .o_ovf  (w_ovf[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_s1       <= '0;
      r_s2       <= '0;
      r_out      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_adv) begin
        r_vld_pipe <= {r_vld_pipe[STAGES-1:1], in_valid};
        if (in_valid)      r_s1  <= w_s1;
        if (r_vld_pipe[1]) r_s2  <= w_s2;
        if (r_vld_pipe[2]) r_out <= w_y;
      end
      // A fresh overflow outranks a same-cycle clear.
      if (w_adv && r_vld_pipe[2] && (|w_ovf)) r_ovf <= 1'b1;
      else if (ovf_clr)                        r_ovf <= 1'b0;
    end
  end

  assign pr        = r_out[0];
  assign pi        = r_out[1];
  assign qr        = r_out[2];
  assign qi        = r_out[3];
  assign out_valid = r_vld_pipe[STAGES];
  assign ovf       = r_ovf;
endmodule

// File: tb/tb_butterfly_r2_cfg.sv
// Scoreboard bench: two butterfly instances (round+saturate, truncate+wrap) share one stimulus stream.
module tb_butterfly_r2_cfg;
  localparam int DW = 16;
  localparam int TW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, inv = 1'b0, scale = 1'b0, out_ready = 1'b1, ovf_clr = 1'b0;
  logic [DW-1:0] ar = '0, ai = '0, br = '0, bi = '0;
  logic [TW-1:0] wr = '0, wi = '0;
  logic in_ready1, out_valid1, ovf1, in_ready0, out_valid0, ovf0;
  logic [DW-1:0] pr1, pi1, qr1, qi1, pr0, pi0, qr0, qi0;

  always #5 clk = ~clk;

  butterfly_r2_cfg #(.DW(DW), .TW(TW), .ROUND(1), .SAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .inv(inv), .scale(scale),
    .ar(ar), .ai(ai), .br(br), .bi(bi), .wr(wr), .wi(wi),
    .pr(pr1), .pi(pi1), .qr(qr1), .qi(qi1), .out_valid(out_valid1), .out_ready(out_ready),
    .ovf(ovf1), .ovf_clr(ovf_clr));

  butterfly_r2_cfg #(.DW(DW), .TW(TW), .ROUND(0), .SAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .inv(inv), .scale(scale),
    .ar(ar), .ai(ai), .br(br), .bi(bi), .wr(wr), .wi(wi),
    .pr(pr0), .pi(pi0), .qr(qr0), .qi(qi0), .out_valid(out_valid0), .out_ready(out_ready),
    .ovf(ovf0), .ovf_clr(ovf_clr));

  typedef struct {
    int ar, ai, br, bi, wr, wi;
    bit inv, scl;
    int p1r, p1i, q1r, q1i, p0r, p0i, q0r, q0i;
    bit ov;
  } vec_t;
  typedef struct { int pr, pi, qr, qi; bit ovf; } exp_t;

  vec_t vt[11];
  exp_t eq1[$], eq0[$];
  int   checks = 0, errors = 0, stall_seen = 0;
  bit   ovf_model = 1'b0;
  bit   pst[2];
  int   prv[2][4];

  function automatic vec_t mk(int ar_, int ai_, int br_, int bi_, int wr_, int wi_, bit inv_, bit scl_,
                              int p1r, int p1i, int q1r, int q1i, int p0r, int p0i, int q0r, int q0i, bit ov);
    vec_t v;
    v.ar = ar_; v.ai = ai_; v.br = br_; v.bi = bi_; v.wr = wr_; v.wi = wi_; v.inv = inv_; v.scl = scl_;
    v.p1r = p1r; v.p1i = p1i; v.q1r = q1r; v.q1i = q1i;
    v.p0r = p0r; v.p0i = p0i; v.q0r = q0r; v.q0i = q0i; v.ov = ov;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic mon(input int id, input logic v, input logic [DW-1:0] a, b, c, d, input logic o);
    int   cur[4];
    exp_t e;
    int   sz;
    cur[0] = int'($signed(a)); cur[1] = int'($signed(b));
    cur[2] = int'($signed(c)); cur[3] = int'($signed(d));
    if (pst[id]) begin
      chk($sformatf("d%0d.hold_vld", id), int'(v), 1);
      for (int k = 0; k < 4; k++) chk($sformatf("d%0d.hold_data%0d", id, k), cur[k], prv[id][k]);
    end
    if (v) begin
      sz = (id == 1) ? eq1.size() : eq0.size();
      if (sz == 0) begin
        chk($sformatf("d%0d.unexpected_output", id), 1, 0);
      end else begin
        e = (id == 1) ? eq1[0] : eq0[0];
        chk($sformatf("d%0d.pr", id), cur[0], e.pr);
        chk($sformatf("d%0d.pi", id), cur[1], e.pi);
        chk($sformatf("d%0d.qr", id), cur[2], e.qr);
        chk($sformatf("d%0d.qi", id), cur[3], e.qi);
        chk($sformatf("d%0d.ovf", id), int'(o), int'(e.ovf));
        if (out_ready) begin
          if (id == 1) void'(eq1.pop_front());
          else         void'(eq0.pop_front());
        end
      end
    end
    pst[id] = v && !out_ready;
    prv[id] = cur;
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      pst[0] = 1'b0; pst[1] = 1'b0;
    end else begin
      chk("d1.in_ready", int'(in_ready1), int'(!(out_valid1 && !out_ready)));
      chk("d0.in_ready", int'(in_ready0), int'(!(out_valid0 && !out_ready)));
      mon(1, out_valid1, pr1, pi1, qr1, qi1, ovf1);
      mon(0, out_valid0, pr0, pi0, qr0, qi0, ovf0);
    end
  end

  task automatic send(input int k);
    vec_t v;
    exp_t e;
    bit   ok;
    v = vt[k];
    in_valid = 1'b1;
    ar = DW'(v.ar); ai = DW'(v.ai); br = DW'(v.br); bi = DW'(v.bi);
    wr = TW'(v.wr); wi = TW'(v.wi); inv = v.inv; scale = v.scl;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready1;
      if (!ok) stall_seen++;
      @(posedge clk);
      #1;
    end
    chk($sformatf("handshake.v%0d", k), int'(ok), 1);
    if (ok) begin
      ovf_model = ovf_model | v.ov;
      e.pr = v.p1r; e.pi = v.p1i; e.qr = v.q1r; e.qi = v.q1i; e.ovf = ovf_model;
      eq1.push_back(e);
      e.pr = v.p0r; e.pi = v.p0i; e.qr = v.q0r; e.qi = v.q0i;
      eq0.push_back(e);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while ((eq1.size() != 0 || eq0.size() != 0) && t < 100);
    chk("drain.pending", eq1.size() + eq0.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".pr1"}, int'($signed(pr1)), 0); chk({tag, ".pi1"}, int'($signed(pi1)), 0);
    chk({tag, ".qr1"}, int'($signed(qr1)), 0); chk({tag, ".qi1"}, int'($signed(qi1)), 0);
    chk({tag, ".pr0"}, int'($signed(pr0)), 0); chk({tag, ".pi0"}, int'($signed(pi0)), 0);
    chk({tag, ".qr0"}, int'($signed(qr0)), 0); chk({tag, ".qi0"}, int'($signed(qi0)), 0);
    chk({tag, ".vld1"}, int'(out_valid1), 0);  chk({tag, ".vld0"}, int'(out_valid0), 0);
    chk({tag, ".ovf1"}, int'(ovf1), 0);        chk({tag, ".ovf0"}, int'(ovf0), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int sidx[8];
    // ar ai br bi wr wi inv scl | round+sat P,Q | trunc+wrap P,Q | ovf
    vt[0]  = mk(1000, 0, 2000, 0, 32767, 0, 0, 0,  3000, 0, -1000, 0,  2999, 0, -999, 0, 0);
    vt[1]  = mk(0, 0, 0, 1000, 0, -32768, 0, 0,  1000, 0, -1000, 0,  1000, 0, -1000, 0, 0);
    vt[2]  = mk(0, 0, 0, 1000, 0, -32768, 1, 0,  -1000, 0, 1000, 0,  -1000, 0, 1000, 0, 0);
    vt[3]  = mk(30000, 0, 10000, 0, 32767, 0, 0, 0,  32767, 0, 20000, 0,  -25537, 0, 20001, 0, 1);
    vt[4]  = mk(30000, 0, 10000, 0, 32767, 0, 0, 1,  20000, 0, 10000, 0,  19999, 0, 10000, 0, 0);
    vt[5]  = mk(-30000, 100, -10000, 0, 32767, 0, 0, 0,  -32768, 100, -20000, 100,  25536, 100, -20000, 100, 1);
    vt[6]  = mk(0, 0, 1000, 2000, 0, 32767, 0, 0,  -2000, 1000, 2000, -1000,  -2000, 999, 2000, -999, 0);
    vt[7]  = mk(0, 0, 1000, 2000, 0, 32767, 1, 0,  2000, -1000, -2000, 1000,  1999, -1000, -1999, 1000, 0);
    vt[8]  = mk(-3, 5, 0, 0, 0, 0, 0, 1,  -1, 3, -1, 3,  -2, 2, -2, 2, 0);
    vt[9]  = mk(100, -200, 16384, -16384, 16384, 16384, 0, 0,  16484, -200, -16284, -200,  16484, -200, -16284, -200, 0);
    vt[10] = mk(100, -200, 16384, -16384, 16384, 16384, 1, 0,  100, -16584, 100, 16184,  100, -16584, 100, 16184, 0);
    sidx = '{0, 1, 2, 6, 7, 8, 9, 10};

    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset.in_ready", int'(in_ready1), 1);

    // Latency: presented in cycle 0, visible after the third edge.
    send(0);
    @(negedge clk); chk("latency.c1", int'(out_valid1), 0);
    @(negedge clk); chk("latency.c2", int'(out_valid1), 0);
    @(negedge clk); chk("latency.c3", int'(out_valid1), 1);
    drain();

    // Back-to-back with inv/scale changing per transaction.
    foreach (sidx[i]) if (i > 0) send(sidx[i]);
    drain();

    send(3);
    drain();
    chk("ovf.sticky1", int'(ovf1), 1);
    chk("ovf.sticky0", int'(ovf0), 1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    ovf_model = 1'b0;
    chk("ovf.clear1", int'(ovf1), 0);
    send(4);
    drain();

    // Clear held high while a new overflow lands: the set must win.
    ovf_clr = 1'b1;
    send(5);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = out_valid1;
    end
    ovf_clr = 1'b0;
    chk("setwins.seen", int'(seen), 1);
    drain();
    chk("setwins.sticky1", int'(ovf1), 1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    ovf_model = 1'b0;
    chk("setwins.cleared0", int'(ovf0), 0);

    // Backpressure: out_ready low for 5 cycles in the middle of an 8-deep stream.
    stall_seen = 0;
    fork
      begin
        foreach (sidx[i]) send(sidx[i]);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stream.stall_cycles", stall_seen, 5);

    // Reset with two transactions in flight and a non-zero held output.
    send(3);
    drain();
    send(0);
    send(1);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    eq1.delete();
    eq0.delete();
    ovf_model = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk("postrst.no_stale", int'(out_valid1 | out_valid0), 0);
    end
    @(posedge clk); #1;
    send(9);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
